// File: rtl/mppt_po_sequencer.sv
// Perturb-and-observe MPPT sequencer: one measure/compute/adjust
// cycle per SMPS frame, with tick-based settling and frame timeout.
module mppt_po_sequencer #(
  parameter int STEP      = 4,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int DUTY_INIT = 128,
  parameter int SETTLE    = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tick,
  input  logic        frame_valid,
  input  logic [7:0]  V_panel,
  input  logic [7:0]  I_panel,
  input  logic        hold,
  output logic [7:0]  duty,
  output logic        duty_valid,
  output logic        dir,
  output logic [15:0] power,
  output logic        fault,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MIN9  = 9'(DUTY_MIN);
  localparam logic [8:0] MAX9  = 9'(DUTY_MAX);

  logic [CW-1:0] cnt;
  logic [7:0]    v_lat;
  logic [7:0]    i_lat;
  logic [15:0]   p_prev;
  logic          dir_n;
  logic [8:0]    duty9;
  logic [8:0]    cand;

  // Decrement floors at zero so a tiny duty never wraps past the max clamp
  always_comb begin
    dir_n = dir;
    if (power < p_prev)
      dir_n = ~dir;
    duty9 = {1'b0, duty};
    cand  = duty9 + STEP9;
    if (!dir_n)
      cand = (duty9 >= STEP9) ? (duty9 - STEP9) : 9'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      duty       <= 8'(DUTY_INIT);
      dir        <= 1'b1;
      power      <= 16'd0;
      p_prev     <= 16'd0;
      fault      <= 1'b0;
      duty_valid <= 1'b0;
      cnt        <= '0;
      v_lat      <= 8'd0;
      i_lat      <= 8'd0;
    end else begin
      duty_valid <= 1'b0;
      if (!en) begin
        state  <= S_IDLE;
        duty   <= 8'(DUTY_INIT);
        dir    <= 1'b1;
        p_prev <= 16'd0;
        fault  <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
          S_SETTLE: begin
            if (tick) begin
              if (cnt == CW'(SETTLE - 1)) begin
                state <= S_WAIT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (frame_valid) begin
              v_lat <= V_panel;
              i_lat <= I_panel;
              state <= S_CALC;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == CW'(TIMEOUT - 1)) begin
                state <= S_FAULT;
                fault <= 1'b1;
                duty  <= 8'(DUTY_MIN);
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_CALC: begin
            power <= 16'(v_lat) * 16'(i_lat);
            state <= S_UPDATE;
          end
          S_UPDATE: begin
            p_prev <= power;
            if (!hold) begin
              duty_valid <= 1'b1;
              if (cand > MAX9) begin
                duty <= MAX9[7:0];
                dir  <= 1'b0;
              end else if (cand < MIN9) begin
                duty <= MIN9[7:0];
                dir  <= 1'b1;
              end else begin
                duty <= cand[7:0];
                dir  <= dir_n;
              end
            end
            state <= S_SETTLE;
            cnt   <= '0;
          end
          S_FAULT: begin
            if (frame_valid) begin
              fault  <= 1'b0;
              p_prev <= 16'd0;
              v_lat  <= V_panel;
              i_lat  <= I_panel;
              state  <= S_CALC;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_po_sequencer.sv
// Directed bench for mppt_po_sequencer: vector table of frames
// plus hand-written timeout, hold, enable-drop and reset sequences.
module tb_mppt_po_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tick;
  logic        frame_valid;
  logic [7:0]  V_panel;
  logic [7:0]  I_panel;
  logic        hold;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        dir;
  logic [15:0] power;
  logic        fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #100 clk = ~clk;

  mppt_po_sequencer #(.SETTLE(2), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .frame_valid(frame_valid), .V_panel(V_panel),
    .I_panel(I_panel), .hold(hold), .duty(duty),
    .duty_valid(duty_valid), .dir(dir), .power(power),
    .fault(fault), .state(state)
  );

  typedef struct {
    logic        restart;
    logic [7:0]  v;
    logic [7:0]  i;
    logic [15:0] ep;
    logic [7:0]  ed;
    logic        edir;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic restart();
    en = 1'b0;
    cyc();
    chk("restart_idle", state, 0);
    chk("restart_duty", duty, 128);
    en = 1'b1;
    cyc();
    chk("restart_settle", state, 1);
  endtask

  task automatic settle();
    for (int k = 0; k < 2; k++) begin
      chk("settle_state", state, 1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    chk("wait_state", state, 2);
  endtask

  task automatic frame(input logic [7:0] v, input logic [7:0] i,
                       input logic h, input int ep, input int ed,
                       input int edir, input int edv);
    V_panel = v;
    I_panel = i;
    hold = h;
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    V_panel = 8'hff;
    I_panel = 8'hff;
    chk("calc_state", state, 3);
    cyc();
    chk("update_state", state, 4);
    chk("power", power, ep);
    chk("dv_early", duty_valid, 0);
    cyc();
    chk("dv_pulse", duty_valid, edv);
    chk("duty", duty, ed);
    chk("dir", dir, edir);
    chk("post_state", state, 1);
    cyc();
    chk("dv_end", duty_valid, 0);
    hold = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'd100, 8'd50, 16'd5000, 8'd132, 1'b1};
    tbl[1] = '{1'b0, 8'd100, 8'd40, 16'd4000, 8'd128, 1'b0};
    tbl[2] = '{1'b0, 8'd100, 8'd40, 16'd4000, 8'd124, 1'b0};
    for (int k = 0; k < 29; k++) begin
      tbl[3+k].restart = (k == 0);
      tbl[3+k].v    = 8'(10 + k);
      tbl[3+k].i    = 8'd10;
      tbl[3+k].ep   = 16'((10 + k) * 10);
      tbl[3+k].ed   = 8'((128 + 4 * (k + 1) > 240) ? 240 : 128 + 4 * (k + 1));
      tbl[3+k].edir = (k < 28);
    end

    rst = 1'b1;
    en = 1'b0;
    tick = 1'b0;
    frame_valid = 1'b0;
    V_panel = 8'd0;
    I_panel = 8'd0;
    hold = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_state", state, 0);
      chk("rst_duty", duty, 128);
      chk("rst_dir", dir, 1);
      chk("rst_fault", fault, 0);
      chk("rst_power", power, 0);
      chk("rst_dv", duty_valid, 0);
    end
    V_panel = 8'd77;
    I_panel = 8'd77;
    frame_valid = 1'b1;
    en = 1'b1;
    cyc();
    frame_valid = 1'b0;
    chk("idle_to_settle", state, 1);
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    chk("fv_ignored_settle", state, 1);

    for (int n = 0; n < 32; n++) begin
      if (tbl[n].restart) restart();
      settle();
      frame(tbl[n].v, tbl[n].i, 1'b0, int'(tbl[n].ep),
            int'(tbl[n].ed), int'(tbl[n].edir), 1);
    end

    restart();
    settle();
    for (int k = 0; k < 31; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    chk("to_31_state", state, 2);
    chk("to_31_fault", fault, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("to_state", state, 5);
    chk("to_fault", fault, 1);
    chk("to_duty", duty, 16);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    chk("fault_stays", state, 5);
    frame(8'd10, 8'd10, 1'b0, 100, 20, 1, 1);
    chk("fault_clear", fault, 0);

    settle();
    frame(8'd20, 8'd20, 1'b1, 400, 20, 1, 0);

    settle();
    V_panel = 8'd30;
    I_panel = 8'd30;
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    chk("drop_calc", state, 3);
    en = 1'b0;
    cyc();
    chk("drop_state", state, 0);
    chk("drop_duty", duty, 128);
    chk("drop_dir", dir, 1);
    chk("drop_power", power, 400);

    en = 1'b1;
    cyc();
    settle();
    frame(8'd5, 8'd5, 1'b0, 25, 132, 1, 1);
    #20;
    rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_duty", duty, 128);
    chk("async_power", power, 0);
    chk("async_dir", dir, 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_state", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
